// File: rtl/status_event_monitor.sv
// -----------------------------------------------------------------------------
// status_event_monitor
//
// Watches a registered 3-bit status word, turns error/done rising edges and a
// busy-too-long condition into sticky pending flags, raises a maskable level
// interrupt, and counts error/done rising edges in saturating counters.
//
// Ports
//   clk         in   1      clock, rising edge
//   rst         in   1      asynchronous, active-high reset
//   status_in   in   3      [0] error, [1] busy, [2] done
//   mask_wr     in   1      strobe: mask <= mask_data
//   mask_data   in   3      new mask (1 = bit kept off irq)
//   clr_wr      in   1      strobe: write-1-to-clear of pending
//   clr_data    in   3      pending bits to clear
//   cnt_clr     in   1      strobe: zero both event counters
//   pending     out  3      sticky flags: [0] error rise, [1] done rise,
//                           [2] busy timeout
//   mask        out  3      current mask register
//   irq         out  1      OR(pending & ~mask)
//   err_count   out  CNT_W  saturating count of error rising edges
//   done_count  out  CNT_W  saturating count of done rising edges
// -----------------------------------------------------------------------------
module status_event_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16   // >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       status_in,
  input  logic             mask_wr,
  input  logic [2:0]       mask_data,
  input  logic             clr_wr,
  input  logic [2:0]       clr_data,
  input  logic             cnt_clr,
  output logic [2:0]       pending,
  output logic [2:0]       mask,
  output logic             irq,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] done_count
);

  localparam int               BW      = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0]    TO_MAX  = BW'(TIMEOUT);
  localparam logic [BW-1:0]    TO_PRE  = BW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]       status_q,   status_d;
  logic [BW-1:0]    busy_cnt_q, busy_cnt_d;
  logic [2:0]       pending_q,  pending_d;
  logic [2:0]       mask_q,     mask_d;
  logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic err_rise;
  logic done_rise;
  logic timeout_hit;

  // A rise in the same cycle as cnt_clr leaves the counter at 1, not 0.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                  input logic             rise,
                                                  input logic             clr);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : cur;
    if (rise && base != CNT_MAX) return base + 1'b1;
    return base;
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a value on every path; the defaults
    // up front guarantee that and keep synthesis from inferring latches.
    status_d    = status_in;
    busy_cnt_d  = busy_cnt_q;
    pending_d   = pending_q;
    mask_d      = mask_q;

    err_rise    = status_in[0] & ~status_q[0];
    done_rise   = status_in[2] & ~status_q[2];

    // Counter at TIMEOUT-1 implies the previous sample was busy too; the
    // counter then saturates, so this fires once per busy episode.
    timeout_hit = status_in[1] & status_q[1] & (busy_cnt_q == TO_PRE);

    if (!status_in[1])          busy_cnt_d = '0;
    else if (busy_cnt_q != TO_MAX) busy_cnt_d = busy_cnt_q + 1'b1;

    // Clear first, then OR in the sets so a simultaneous set wins.
    if (clr_wr) pending_d = pending_d & ~clr_data;
    pending_d = pending_d | {timeout_hit, done_rise, err_rise};

    if (mask_wr) mask_d = mask_data;

    err_cnt_d  = next_count(err_cnt_q,  err_rise,  cnt_clr);
    done_cnt_d = next_count(done_cnt_q, done_rise, cnt_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= '0;
      busy_cnt_q <= '0;
      pending_q  <= '0;
      mask_q     <= 3'b111;
      err_cnt_q  <= '0;
      done_cnt_q <= '0;
    end else begin
      status_q   <= status_d;
      busy_cnt_q <= busy_cnt_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      err_cnt_q  <= err_cnt_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign pending    = pending_q;
  assign mask       = mask_q;
  assign irq        = |(pending_q & ~mask_q);
  assign err_count  = err_cnt_q;
  assign done_count = done_cnt_q;

endmodule

// File: tb/tb_status_event_monitor.sv
module tb_status_event_monitor;

  logic       clk;
  logic       rst;
  logic [2:0] status_in;
  logic       mask_wr;
  logic [2:0] mask_data;
  logic       clr_wr;
  logic [2:0] clr_data;
  logic       cnt_clr;
  logic [2:0] pending;
  logic [2:0] mask;
  logic       irq;
  logic [7:0] err_count;
  logic [7:0] done_count;

  int n_vec;
  int n_bad;

  status_event_monitor #(.CNT_W(8), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .status_in  (status_in),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .clr_wr     (clr_wr),
    .clr_data   (clr_data),
    .cnt_clr    (cnt_clr),
    .pending    (pending),
    .mask       (mask),
    .irq        (irq),
    .err_count  (err_count),
    .done_count (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] status;
    logic       mask_wr;
    logic [2:0] mask_data;
    logic       clr_wr;
    logic [2:0] clr_data;
    logic       cnt_clr;
    logic [2:0] exp_pending;
    logic [2:0] exp_mask;
    logic       exp_irq;
    logic [7:0] exp_err;
    logic [7:0] exp_done;
  } vec_t;

  vec_t vecs [12];

  // {pending, mask, irq, err_count, done_count}
  function automatic logic [31:0] pack_all(input logic [2:0] p, input logic [2:0] m,
                                           input logic i, input logic [7:0] e,
                                           input logic [7:0] d);
    return {9'd0, p, m, i, e, d};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] st, input logic mw, input logic [2:0] md,
                       input logic cw, input logic [2:0] cd, input logic cc);
    status_in = st;
    mask_wr   = mw;
    mask_data = md;
    clr_wr    = cw;
    clr_data  = cd;
    cnt_clr   = cc;
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next one.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] cur_all();
    return pack_all(pending, mask, irq, err_count, done_count);
  endfunction

  initial begin
    n_vec = 0;
    n_bad = 0;

    //            st    mw  md    cw  cd    cc   pend  mask  irq err   done
    vecs[0]  = '{3'b000, 1, 3'b000, 0, 3'b000, 0, 3'b000, 3'b000, 0, 8'd0, 8'd0};
    vecs[1]  = '{3'b001, 0, 3'b000, 0, 3'b000, 0, 3'b001, 3'b000, 1, 8'd1, 8'd0};
    vecs[2]  = '{3'b000, 0, 3'b000, 0, 3'b000, 0, 3'b001, 3'b000, 1, 8'd1, 8'd0};
    vecs[3]  = '{3'b000, 0, 3'b000, 1, 3'b001, 0, 3'b000, 3'b000, 0, 8'd1, 8'd0};
    vecs[4]  = '{3'b100, 1, 3'b111, 0, 3'b000, 0, 3'b010, 3'b111, 0, 8'd1, 8'd1};
    vecs[5]  = '{3'b100, 1, 3'b101, 0, 3'b000, 0, 3'b010, 3'b101, 1, 8'd1, 8'd1};
    vecs[6]  = '{3'b000, 0, 3'b000, 1, 3'b010, 0, 3'b000, 3'b101, 0, 8'd1, 8'd1};
    vecs[7]  = '{3'b100, 0, 3'b000, 1, 3'b010, 0, 3'b010, 3'b101, 1, 8'd1, 8'd2};
    vecs[8]  = '{3'b101, 0, 3'b000, 1, 3'b010, 1, 3'b001, 3'b101, 0, 8'd1, 8'd0};
    vecs[9]  = '{3'b000, 1, 3'b000, 1, 3'b001, 1, 3'b000, 3'b000, 0, 8'd0, 8'd0};
    vecs[10] = '{3'b110, 0, 3'b000, 0, 3'b000, 0, 3'b010, 3'b000, 1, 8'd0, 8'd1};
    vecs[11] = '{3'b000, 0, 3'b000, 1, 3'b010, 0, 3'b000, 3'b000, 0, 8'd0, 8'd1};

    rst = 1'b1;
    drive(3'b000, 0, 3'b000, 0, 3'b000, 0);
    #12;
    check("reset_state", cur_all(), pack_all(3'b000, 3'b111, 1'b0, 8'd0, 8'd0));
    @(negedge clk);
    rst = 1'b0;

    // Table: one clock per row, all outputs compared after the edge.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].status, vecs[i].mask_wr, vecs[i].mask_data,
            vecs[i].clr_wr, vecs[i].clr_data, vecs[i].cnt_clr);
      tick();
      check($sformatf("vec%0d", i), cur_all(),
            pack_all(vecs[i].exp_pending, vecs[i].exp_mask, vecs[i].exp_irq,
                     vecs[i].exp_err, vecs[i].exp_done));
    end

    // Busy for 15 samples: no timeout.
    for (int i = 1; i <= 15; i++) begin
      drive(3'b010, 0, 3'b000, 0, 3'b000, 0);
      tick();
      check($sformatf("busy15_s%0d", i), {29'd0, pending}, 32'd0);
    end
    drive(3'b000, 0, 3'b000, 0, 3'b000, 0);
    tick();
    check("busy_gap", {29'd0, pending}, 32'd0);

    // Busy for 16 samples: timeout on the 16th.
    for (int i = 1; i <= 16; i++) begin
      drive(3'b010, 0, 3'b000, 0, 3'b000, 0);
      tick();
      check($sformatf("busy16_s%0d", i), {28'd0, irq, pending},
            (i == 16) ? 32'b1_100 : 32'd0);
    end
    drive(3'b010, 0, 3'b000, 1, 3'b100, 0);
    tick();
    check("timeout_clear", {28'd0, irq, pending}, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      drive(3'b010, 0, 3'b000, 0, 3'b000, 0);
      tick();
      check($sformatf("busy_hold_s%0d", i), {29'd0, pending}, 32'd0);
    end
    drive(3'b000, 0, 3'b000, 0, 3'b000, 0);
    tick();

    // Error counter saturation, then cnt_clr coinciding with a rise.
    for (int i = 0; i < 300; i++) begin
      drive(3'b001, 0, 3'b000, 0, 3'b000, 0);
      tick();
      drive(3'b000, 0, 3'b000, 0, 3'b000, 0);
      tick();
    end
    check("err_saturate", {24'd0, err_count}, 32'd255);
    drive(3'b001, 0, 3'b000, 0, 3'b000, 1);
    tick();
    check("cnt_clr_with_rise", {16'd0, err_count, done_count}, {16'd0, 8'd1, 8'd0});
    drive(3'b000, 0, 3'b000, 0, 3'b000, 0);
    tick();

    // Build pending = 111 with nonzero counters, then reset mid-cycle.
    for (int i = 0; i < 16; i++) begin
      drive(3'b010, 0, 3'b000, 0, 3'b000, 0);
      tick();
    end
    drive(3'b111, 0, 3'b000, 0, 3'b000, 0);
    tick();
    check("pre_reset", cur_all(), pack_all(3'b111, 3'b000, 1'b1, 8'd2, 8'd1));
    drive(3'b100, 0, 3'b000, 0, 3'b000, 0);
    #2 rst = 1'b1;
    #1;
    check("async_reset", cur_all(), pack_all(3'b000, 3'b111, 1'b0, 8'd0, 8'd0));
    @(negedge clk);
    check("reset_held", cur_all(), pack_all(3'b000, 3'b111, 1'b0, 8'd0, 8'd0));
    rst = 1'b0;
    tick();
    check("release_done_edge", cur_all(), pack_all(3'b010, 3'b111, 1'b0, 8'd0, 8'd1));
    tick();
    check("release_done_hold", cur_all(), pack_all(3'b010, 3'b111, 1'b0, 8'd0, 8'd1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
